// File: rtl/multicycle_adder.sv
`timescale 1ns/1ps
// multicycle_adder: digit-serial add/subtract. Processes DIGIT bits per clock through a small
// ripple, keeps the carry in a register between steps, and posts sum/cout/ovf with a done pulse.
module multicycle_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] psum;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_cmsb;
  logic [WIDTH-1:0] psum_nxt;
  logic             last_step;

  // Ripple across the current digit; operands are shifted so the active digit is always at the LSBs.
  always_comb begin : digit_ripple
    logic c;
    c        = carry_q;
    dig_sum  = '0;
    dig_cmsb = 1'b0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      dig_cmsb   = c;
      dig_sum[i] = a_q[i] ^ b_q[i] ^ c;
      c          = (a_q[i] & b_q[i]) | (c & (a_q[i] ^ b_q[i]));
    end
    dig_cout = c;
  end

  // New digit enters at the top; after STEPS shifts the LSB digit has reached bit 0.
  assign psum_nxt  = (psum >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));
  assign last_step = (cnt == CW'(STEPS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_RUN;
            busy    <= 1'b1;
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= cin ^ sub;
            cnt     <= '0;
            psum    <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= dig_cout;
          psum    <= psum_nxt;
          cnt     <= cnt + CW'(1);
          if (last_step) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            sum   <= psum_nxt;
            cout  <= dig_cout;
            ovf   <= dig_cout ^ dig_cmsb;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/multicycle_adder.md
# multicycle_adder

Parametrised multi-cycle add/subtract unit, the sequential successor to the team's single-bit full adder. It accepts two WIDTH-bit operands plus carry-in on a start pulse. It then processes DIGIT bits per clock through a DIGIT-bit ripple of full adders, with the carry held in a register between steps. It reports sum, carry-out and signed overflow with a one-cycle done pulse. It sits in area-constrained datapaths where a full-width single-cycle adder is not wanted.

## Interface
- WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT, ≥ 2
- DIGIT, 1, bits processed per clock; 1 ≤ DIGIT ≤ WIDTH
- Clk  input  1  single clock; all state changes on rising edge
- Rst  input  1  reset, asynchronous and active-high; clears all state and outputs immediately
- Start  input  1  request; sampled only when not Busy
- Sub  input  1  0: A + B + Cin; 1: A − B − Cin (borrow-in)
- A  input  WIDTH  operand A, unsigned or two's complement
- B  input  WIDTH  operand B
- Cin  input  1  carry-in (Sub=0) or borrow-in (Sub=1)
- Busy  output  1  high while an operation is in progress
- Done  output  1  one-cycle pulse when a result is valid
- Sum  output  WIDTH  result register
- Cout  output  1  carry out of the MSB. For Sub=1 it is NOT borrow-out: 1 means no borrow.
- Ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- Number of steps: STEPS = WIDTH/DIGIT.
- States:
  - IDLE → RUN on Start.
  - RUN → RUN while step counter < STEPS−1.
  - RUN → DONE at the last step.
  - DONE → RUN if Start, else IDLE.
- Accept edge (Start=1 in IDLE or DONE):
  - Latch A.
  - Latch B (Sub=1: latch ~B).
  - Load the internal carry with Cin (Sub=1: ~Cin).
  - Clear the step counter.
  - Clear the internal partial-sum register.
- Each RUN edge:
  - Add operand bits [DIGIT·k+DIGIT−1 : DIGIT·k] plus the carry register.
  - Write the DIGIT result bits into the partial-sum register.
  - Update the carry register.
  - Increment the counter.
  - Digit 0 (LSBs) comes first.
- Last RUN edge: transfer the partial sum to Sum, the final carry to Cout, and the overflow to Ovf, in one edge. Ovf is computed from the carry into bit WIDTH−1 and the carry out of it.
- Sum/Cout/Ovf hold their value from completion until the next completion. Intermediate digits are never visible on Sum.
- Start is ignored while in RUN; there is no queueing. Operands and Sub may change freely after the accept edge.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Reset (any time, including mid-RUN):
  - State goes to IDLE and the in-flight operation is discarded.
  - Busy=0, Done=0, Sum=0, Cout=0, Ovf=0.
  - Counter, carry and partial sum are cleared.
  - Start asserted during reset is not accepted. The first accept is on the first rising edge with Rst low.

## Timing
- Let edge 0 be the edge that samples Start=1.
- Busy is high from edge 0 through edge STEPS (STEPS cycles). Busy is high in RUN only.
- Done is high for exactly one cycle, from edge STEPS to edge STEPS+1. Sum/Cout/Ovf are valid from edge STEPS.
- Latency is STEPS edges from accept to valid result.
- Back-to-back: Start sampled in the DONE cycle is accepted. Throughput is one result per STEPS+1 cycles.
- DIGIT=WIDTH gives STEPS=1: Busy is high for 1 cycle and Done is high at edge 1.
- Done and Busy are never high together.

## Test plan
- Reset values: assert Rst mid-cycle with no clock edge → Busy, Done, Sum, Cout, Ovf all 0 immediately. Release Rst and hold Start=0 for 5 cycles → outputs stay 0 and there is no Done.
- Exhaustive at WIDTH=4, DIGIT=1 and DIGIT=2: all A, B, Cin, Sub combinations (1024 ops).
  - Each op must give Sum = (A±B±Cin) mod 16, correct Cout and Ovf.
  - Done must arrive exactly STEPS edges after accept.
- WIDTH=8, DIGIT=1 corner values:
  - A=0xFF, B=0x01, Cin=0, Sub=0 → Sum=0x00, Cout=1, Ovf=0.
  - A=0x7F, B=0x01, Sub=0 → Sum=0x80, Cout=0, Ovf=1.
  - A=0x00, B=0x01, Cin=0, Sub=1 → Sum=0xFF, Cout=0, Ovf=0.
  - A=0x80, B=0x01, Sub=1 → Sum=0x7F, Cout=1, Ovf=1.
- Start held high continuously for 30 cycles with operands changing every cycle (WIDTH=8, DIGIT=1):
  - An accept occurs every 9 cycles.
  - Each result matches the operands sampled at its accept edge.
  - Sum holds between Done pulses.
- Reset mid-operation: accept A=0x55, B=0x0A. Assert Rst after 3 RUN edges, release, and issue a new op A=0x10, B=0x20 → no Done for the aborted op, then Sum=0x30, Cout=0 with Done at the expected edge.
- DIGIT=WIDTH=8: A=0xC8, B=0x64, Cin=1 → Busy for 1 cycle, then Done with Sum=0x2D and Cout=1.
